// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: state encoding, port
// indices and the access-code widths of the data-memory interface.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CORE  = 2'd1,
    S_DBG   = 2'd2,
    S_BURST = 2'd3
  } arb_state_t;

  localparam logic PORT_C = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int WE_W = 2;
  localparam int RE_W = 3;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of core, debug and memory-side signals around the arbiter.
// master = requesters plus memory model, slave = the arbiter itself.
interface dmem_arbiter_if
  import dmem_arbiter_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic            c_req;
  logic [31:0]     c_addr;
  logic [31:0]     c_wdata;
  logic [WE_W-1:0] c_we;
  logic [RE_W-1:0] c_re;
  logic            c_gnt;
  logic            c_stall;

  logic            d_req;
  logic            d_lock;
  logic [31:0]     d_addr;
  logic [31:0]     d_wdata;
  logic [WE_W-1:0] d_we;
  logic [RE_W-1:0] d_re;
  logic            d_gnt;

  logic [31:0]     m_addr;
  logic [31:0]     m_wdata;
  logic [WE_W-1:0] m_we;
  logic [RE_W-1:0] m_re;
  logic [31:0]     m_rdata;
  logic [31:0]     rdata;

  logic [CNT_W-1:0] conflict_cnt;

  modport master (
    output c_req, c_addr, c_wdata, c_we, c_re,
    output d_req, d_lock, d_addr, d_wdata, d_we, d_re,
    output m_rdata,
    input  c_gnt, c_stall, d_gnt,
    input  m_addr, m_wdata, m_we, m_re, rdata, conflict_cnt
  );

  modport slave (
    input  c_req, c_addr, c_wdata, c_we, c_re,
    input  d_req, d_lock, d_addr, d_wdata, d_we, d_re,
    input  m_rdata,
    output c_gnt, c_stall, d_gnt,
    output m_addr, m_wdata, m_we, m_re, rdata, conflict_cnt
  );

endinterface

// File: rtl/dmem_arbiter_sat_counter.sv
// Up-counter that sticks at MAX instead of wrapping; clr has priority over inc.
module sat_counter #(
  parameter int           W   = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  // Saturating count register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX)) begin
      cnt <= cnt + W'(1);
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Same-cycle arbiter sharing the single-port data memory between the core
// and the debug loader: round-robin, locked debug bursts, core starvation cap.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_BURST    = 8,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  localparam logic [7:0] MAX_BURST_C    = 8'(MAX_BURST);
  localparam logic [7:0] STARVE_LIMIT_C = 8'(STARVE_LIMIT);

  arb_state_t state_r;
  logic       last_gnt_r;
  logic [7:0] burst_cnt_r;
  logic [7:0] starve_cnt_r;

  logic c_req_s;
  logic d_req_s;
  logic burst_hold_s;
  logic c_gnt_s;
  logic d_gnt_s;
  logic c_stall_s;

  // While reset is held every request is masked so the outputs sit idle.
  assign c_req_s      = bus.c_req & rst;
  assign d_req_s      = bus.d_req & rst;
  assign burst_hold_s = (state_r == S_BURST) && d_req_s && bus.d_lock &&
                        (burst_cnt_r < MAX_BURST_C);
  assign c_stall_s    = c_req_s & ~c_gnt_s;

  // Grant resolution: starvation cap, then burst, then round-robin
  always_comb begin
    c_gnt_s = 1'b0;
    d_gnt_s = 1'b0;
    if (c_req_s && (starve_cnt_r == STARVE_LIMIT_C)) begin
      c_gnt_s = 1'b1;
    end else if (burst_hold_s) begin
      d_gnt_s = 1'b1;
    end else if (c_req_s && d_req_s) begin
      if (last_gnt_r == PORT_D) begin
        c_gnt_s = 1'b1;
      end else begin
        d_gnt_s = 1'b1;
      end
    end else if (c_req_s) begin
      c_gnt_s = 1'b1;
    end else if (d_req_s) begin
      d_gnt_s = 1'b1;
    end else begin
      c_gnt_s = 1'b0;
      d_gnt_s = 1'b0;
    end
  end

  // Memory-side mux driven by the winning port
  always_comb begin
    bus.m_addr  = 32'd0;
    bus.m_wdata = 32'd0;
    bus.m_we    = 2'd0;
    bus.m_re    = 3'd0;
    case ({c_gnt_s, d_gnt_s})
      2'b10: begin
        bus.m_addr  = bus.c_addr;
        bus.m_wdata = bus.c_wdata;
        bus.m_we    = bus.c_we;
        bus.m_re    = bus.c_re;
      end
      2'b01: begin
        bus.m_addr  = bus.d_addr;
        bus.m_wdata = bus.d_wdata;
        bus.m_we    = bus.d_we;
        bus.m_re    = bus.d_re;
      end
      default: begin
        bus.m_addr  = 32'd0;
        bus.m_wdata = 32'd0;
        bus.m_we    = 2'd0;
        bus.m_re    = 3'd0;
      end
    endcase
  end

  assign bus.c_gnt   = c_gnt_s;
  assign bus.d_gnt   = d_gnt_s;
  assign bus.c_stall = c_stall_s;
  assign bus.rdata   = bus.m_rdata;

  // Arbitration state, round-robin pointer and burst length
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= S_IDLE;
      last_gnt_r  <= PORT_D;
      burst_cnt_r <= 8'd0;
    end else if (c_gnt_s) begin
      state_r     <= S_CORE;
      last_gnt_r  <= PORT_C;
      burst_cnt_r <= 8'd0;
    end else if (d_gnt_s) begin
      last_gnt_r <= PORT_D;
      if (bus.d_lock) begin
        state_r     <= S_BURST;
        // A locked grant outside a live burst opens a fresh one.
        burst_cnt_r <= burst_hold_s ? (burst_cnt_r + 8'd1) : 8'd1;
      end else begin
        state_r     <= S_DBG;
        burst_cnt_r <= 8'd0;
      end
    end else begin
      state_r     <= S_IDLE;
      last_gnt_r  <= last_gnt_r;
      burst_cnt_r <= 8'd0;
    end
  end

  sat_counter #(
    .W   (8),
    .MAX (STARVE_LIMIT_C)
  ) u_starve_cnt (
    .clk (clk),
    .rst (rst),
    .inc (c_stall_s),
    .clr (c_gnt_s | ~c_req_s),
    .cnt (starve_cnt_r)
  );

  sat_counter #(
    .W   (CNT_W),
    .MAX ({CNT_W{1'b1}})
  ) u_conflict_cnt (
    .clk (clk),
    .rst (rst),
    .inc (c_stall_s),
    .clr (1'b0),
    .cnt (bus.conflict_cnt)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a default-parameter instance plus a narrow
// conflict-counter instance used to reach saturation quickly.
module tb_dmem_arbiter;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   n_stall;

  dmem_arbiter_if #(.CNT_W(16)) bus ();
  dmem_arbiter_if #(.CNT_W(4))  sbus ();

  dmem_arbiter #(.MAX_BURST(8), .STARVE_LIMIT(4), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  dmem_arbiter #(.MAX_BURST(8), .STARVE_LIMIT(4), .CNT_W(4)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.c_req  = 1'b0; bus.c_addr = 32'd0; bus.c_wdata = 32'd0;
    bus.c_we   = 2'd0; bus.c_re   = 3'd0;
    bus.d_req  = 1'b0; bus.d_lock = 1'b0; bus.d_addr  = 32'd0;
    bus.d_wdata = 32'd0; bus.d_we = 2'd0; bus.d_re    = 3'd0;
    bus.m_rdata = 32'd0;
    sbus.c_req = 1'b0; sbus.c_addr = 32'd0; sbus.c_wdata = 32'd0;
    sbus.c_we  = 2'd0; sbus.c_re   = 3'd0;
    sbus.d_req = 1'b0; sbus.d_lock = 1'b0; sbus.d_addr = 32'd0;
    sbus.d_wdata = 32'd0; sbus.d_we = 2'd0; sbus.d_re = 3'd0;
    sbus.m_rdata = 32'd0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    n_stall = 0;
    rst     = 1'b1;
    clear_inputs();
    #2 rst = 1'b0;

    // Reset state, with a core request that must be ignored
    @(negedge clk);
    chk("rst_c_gnt", 32'(bus.c_gnt), 32'd0);
    chk("rst_d_gnt", 32'(bus.d_gnt), 32'd0);
    chk("rst_conflict", 32'(bus.conflict_cnt), 32'd0);
    bus.c_req = 1'b1;
    bus.d_req = 1'b1;
    #1;
    chk("rst_req_c_gnt", 32'(bus.c_gnt), 32'd0);
    chk("rst_req_d_gnt", 32'(bus.d_gnt), 32'd0);
    chk("rst_req_stall", 32'(bus.c_stall), 32'd0);
    next_cycle();
    rst = 1'b1;
    clear_inputs();

    // Test 1: core alone
    bus.c_req = 1'b1; bus.c_addr = 32'h10; bus.c_we = 2'b01;
    bus.c_wdata = 32'h1234_5678; bus.m_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t1_c_gnt", 32'(bus.c_gnt), 32'd1);
      chk("t1_m_addr", bus.m_addr, 32'h10);
      chk("t1_m_we", 32'(bus.m_we), 32'd1);
      chk("t1_m_wdata", bus.m_wdata, 32'h1234_5678);
      chk("t1_stall", 32'(bus.c_stall), 32'd0);
      chk("t1_rdata", bus.rdata, 32'hDEAD_BEEF);
      next_cycle();
    end
    chk("t1_conflict", 32'(bus.conflict_cnt), 32'd0);

    // Test 2: unlocked contention alternates starting with the core
    do_reset();
    bus.c_req = 1'b1; bus.c_addr = 32'h10;
    bus.d_req = 1'b1; bus.d_addr = 32'h200; bus.d_we = 2'b10; bus.d_re = 3'b011;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_c_gnt", 32'(bus.c_gnt), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("t2_d_gnt", 32'(bus.d_gnt), (i % 2 == 0) ? 32'd0 : 32'd1);
      chk("t2_stall", 32'(bus.c_stall), (i % 2 == 0) ? 32'd0 : 32'd1);
      chk("t2_m_addr", bus.m_addr, (i % 2 == 0) ? 32'h10 : 32'h200);
      chk("t2_m_re", 32'(bus.m_re), (i % 2 == 0) ? 32'd0 : 32'd3);
      next_cycle();
    end
    chk("t2_conflict", 32'(bus.conflict_cnt), 32'd2);

    // Test 3: full locked burst, then the core wins on cycle 9
    do_reset();
    bus.d_req = 1'b1; bus.d_lock = 1'b1; bus.d_we = 2'b10; bus.d_addr = 32'h300;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t3_d_gnt", 32'(bus.d_gnt), 32'd1);
      chk("t3_m_we", 32'(bus.m_we), 32'd2);
      next_cycle();
    end
    bus.c_req = 1'b1; bus.c_addr = 32'h44;
    @(negedge clk);
    chk("t3_c9_c_gnt", 32'(bus.c_gnt), 32'd1);
    chk("t3_c9_d_gnt", 32'(bus.d_gnt), 32'd0);
    chk("t3_c9_m_addr", bus.m_addr, 32'h44);

    // Test 3b: core idle at burst end, so debug restarts a burst counting from 1
    do_reset();
    bus.d_req = 1'b1; bus.d_lock = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("t3b_d_gnt", 32'(bus.d_gnt), 32'd1);
      next_cycle();
    end
    bus.c_req = 1'b1;
    @(negedge clk);
    chk("t3b_c_gnt", 32'(bus.c_gnt), 32'd1);
    chk("t3b_d_gnt", 32'(bus.d_gnt), 32'd0);

    // Test 4: starvation cap breaks into a burst
    do_reset();
    bus.d_req = 1'b1; bus.d_lock = 1'b1;
    @(negedge clk);
    chk("t4_first_d_gnt", 32'(bus.d_gnt), 32'd1);
    next_cycle();
    bus.c_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_denied_c_gnt", 32'(bus.c_gnt), 32'd0);
      chk("t4_denied_d_gnt", 32'(bus.d_gnt), 32'd1);
      chk("t4_denied_stall", 32'(bus.c_stall), 32'd1);
      next_cycle();
    end
    @(negedge clk);
    chk("t4_forced_c_gnt", 32'(bus.c_gnt), 32'd1);
    chk("t4_forced_d_gnt", 32'(bus.d_gnt), 32'd0);
    next_cycle();
    chk("t4_starve_clr", 32'(dut.starve_cnt_r), 32'd0);
    chk("t4_conflict", 32'(bus.conflict_cnt), 32'd4);

    // Test 5: reset mid-burst abandons it
    do_reset();
    bus.d_req = 1'b1; bus.d_lock = 1'b1; bus.d_we = 2'b01; bus.d_re = 3'b101;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) bus.c_req = 1'b1;
      next_cycle();
    end
    chk("t5_pre_conflict", 32'(bus.conflict_cnt), 32'd2);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_c_gnt", 32'(bus.c_gnt), 32'd0);
    chk("t5_d_gnt", 32'(bus.d_gnt), 32'd0);
    chk("t5_m_we", 32'(bus.m_we), 32'd0);
    chk("t5_m_re", 32'(bus.m_re), 32'd0);
    chk("t5_stall", 32'(bus.c_stall), 32'd0);
    chk("t5_conflict", 32'(bus.conflict_cnt), 32'd0);
    next_cycle();
    rst = 1'b1;
    bus.d_req = 1'b0; bus.d_lock = 1'b0; bus.c_req = 1'b1;
    @(negedge clk);
    chk("t5_after_c_gnt", 32'(bus.c_gnt), 32'd1);
    chk("t5_after_stall", 32'(bus.c_stall), 32'd0);

    // Test 6: narrow conflict counter saturates and holds
    do_reset();
    sbus.c_req = 1'b1; sbus.d_req = 1'b1; sbus.d_lock = 1'b1;
    n_stall = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sbus.c_stall) n_stall++;
      next_cycle();
      if (i % 6 == 5)
        chk("t6_conflict", 32'(sbus.conflict_cnt), (n_stall > 15) ? 32'd15 : 32'(n_stall));
    end
    chk("t6_stalls_seen", (n_stall > 15) ? 32'd1 : 32'd0, 32'd1);
    chk("t6_saturated", 32'(sbus.conflict_cnt), 32'hF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the core load/store path (port C) and a debug/program-loader port (port D).
- Sits between the core datapath and the data memory. It drives the memory address, write data, write-enable and read-enable, and routes read data back to both requesters.
- Access is same-cycle, to suit the single-cycle core. The block resolves contention with round-robin, supports locked debug bursts and enforces a core starvation limit.
- It reports core stall and a saturating conflict counter.

Parameters:
- MAX_BURST, 8, maximum consecutive locked grants to port D. Legal range 1..255.
- STARVE_LIMIT, 4, consecutive denied cycles of a pending core request before the core is forced a grant. Legal range 1..255.
- CNT_W, 16, width of the conflict counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- c_req  in  1  core access request.
- c_addr  in  32  core byte address.
- c_wdata  in  32  core write data.
- c_we  in  2  core write-enable code, passed to memory unchanged.
- c_re  in  3  core read-enable code, passed to memory unchanged.
- c_gnt  out  1  core granted this cycle.
- c_stall  out  1  c_req & ~c_gnt; the core must hold its PC.
- d_req  in  1  debug access request.
- d_lock  in  1  debug requests burst ownership; valid only with d_req.
- d_addr  in  32  debug byte address.
- d_wdata  in  32  debug write data.
- d_we  in  2  debug write-enable code.
- d_re  in  3  debug read-enable code.
- d_gnt  out  1  debug granted this cycle.
- m_addr  out  32  memory address.
- m_wdata  out  32  memory write data.
- m_we  out  2  memory write-enable.
- m_re  out  3  memory read-enable.
- m_rdata  in  32  memory read data (combinational).
- rdata  out  32  equals m_rdata; valid to whichever port is granted.
- conflict_cnt  out  CNT_W  saturating count of cycles where c_stall = 1.

Behaviour:
- State register holds one of four states, reset value S_IDLE:
  - S_IDLE: no grant last cycle.
  - S_CORE: core granted last cycle.
  - S_DBG: debug granted last cycle, unlocked.
  - S_BURST: debug granted last cycle, locked.
- Other registers and their reset values:
  - last_gnt = D, so the core wins the first contention.
  - burst_cnt = 0 (8-bit).
  - starve_cnt = 0 (8-bit).
  - conflict_cnt = 0.
- Grant is combinational from the current state, counters and requests. The memory access completes in the same cycle, with zero latency. Rules in priority order:
  1. c_req and starve_cnt == STARVE_LIMIT: grant C, even during a burst.
  2. state == S_BURST, d_req, d_lock, and burst_cnt < MAX_BURST: grant D.
  3. c_req and d_req both set: grant the port that is not last_gnt.
  4. Only one requester: grant it.
  5. Neither requester: no grant.
- c_gnt and d_gnt are never both 1.
- Memory mux:
  - Granted port drives m_addr, m_wdata, m_we and m_re.
  - With no grant: m_we = 0, m_re = 0, m_addr = 0, m_wdata = 0.
- Next state:
  - C granted: S_CORE.
  - D granted with d_lock: S_BURST.
  - D granted without d_lock: S_DBG.
  - Otherwise: S_IDLE.
  - last_gnt updates only on a grant.
- burst_cnt:
  - Loads 1 on the entry grant into S_BURST.
  - Increments on each further locked D grant.
  - Cleared on any cycle without a locked D grant.
  - When burst_cnt == MAX_BURST, the lock is ignored and rule 3 applies. If the core is idle, D may start a new burst, with burst_cnt reloaded to 1.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, when c_req & ~c_gnt.
  - Cleared when c_gnt = 1 or c_req = 0.
- conflict_cnt:
  - Increments when c_stall = 1.
  - Holds at all-ones; there is no wrap.
- Request inputs are ignored while rst is low, and all outputs show their idle values. Reset taking effect mid-burst returns the block to S_IDLE with the counters cleared on the next active edge; a partial burst is abandoned.

Decomposition:
- Shared package holds:
  - the state encoding (S_IDLE = 2'd0, S_CORE = 2'd1, S_DBG = 2'd2, S_BURST = 2'd3);
  - port-index constants PORT_C = 1'b0 and PORT_D = 1'b1;
  - width constants for the WE (2) and RE (3) codes, reused from the data-memory interface.
- Sub-module sat_counter (parameter width, inc/clr inputs, saturating) is natural. It is instantiated for starve_cnt and conflict_cnt.

Test Plan:
1. Reset, then c_req = 1 alone for 3 cycles at c_addr = 0x10, c_we = 2'b01 -> c_gnt = 1 every cycle, m_addr = 0x10, c_stall = 0, conflict_cnt = 0.
2. c_req and d_req both held, with no lock, for 4 cycles after reset -> grants alternate C, D, C, D; c_stall = 0, 1, 0, 1; conflict_cnt = 2.
3. d_req = d_lock = 1 from an idle start with MAX_BURST = 8, core idle -> d_gnt = 1 for 8 cycles. On cycle 9, with c_req = 1, the core is granted.
4. Burst in progress, c_req raised at the 2nd burst cycle with STARVE_LIMIT = 4, MAX_BURST = 8 -> core denied 4 cycles, granted on the 5th. starve_cnt returns to 0 and conflict_cnt = 4.
5. rst driven low mid-burst (burst_cnt = 3) -> next cycle has no grants, m_we = 0, m_re = 0, conflict_cnt = 0. After release, a c_req alone is granted immediately.
6. Core stalled continuously for 2^16 + 5 cycles -> conflict_cnt = 0xFFFF and holds.
